// File: rtl/cmd_timing_gate_if.sv
// Request / issue / timing-select bundle between a command scheduler and cmd_timing_gate.
// master = scheduler side (drives requests), slave = gate side.
interface cmd_timing_gate_if #(
   parameter int CMD_TYPE_WIDTH = 3,
   parameter int RNK_SEL_WIDTH  = 1,
   parameter int BG_SEL_WIDTH   = 2,
   parameter int BNK_SEL_WIDTH  = 2
);
   // Handshake: a request transfers on a rising clk edge where req_valid && req_ready.
   // req_ready never depends on req_valid; the requester holds its payload until accepted.
   logic                      req_valid;
   logic                      req_ready;
   logic [CMD_TYPE_WIDTH-1:0] req_cmd;
   logic [RNK_SEL_WIDTH-1:0]  req_rnk;
   logic [BG_SEL_WIDTH-1:0]   req_bg;
   logic [BNK_SEL_WIDTH-1:0]  req_bnk;

   logic                      issue_valid;
   logic [CMD_TYPE_WIDTH-1:0] issue_cmd;
   logic [RNK_SEL_WIDTH-1:0]  issue_rnk;
   logic [BG_SEL_WIDTH-1:0]   issue_bg;
   logic [BNK_SEL_WIDTH-1:0]  issue_bnk;

   logic [CMD_TYPE_WIDTH-1:0] tm_sel_cmd;
   logic [RNK_SEL_WIDTH-1:0]  tm_sel_rnk;
   logic [BG_SEL_WIDTH-1:0]   tm_sel_bg;
   logic [BNK_SEL_WIDTH-1:0]  tm_sel_bnk;

   modport master (
      output req_valid, req_cmd, req_rnk, req_bg, req_bnk,
      input  req_ready,
      input  issue_valid, issue_cmd, issue_rnk, issue_bg, issue_bnk,
      input  tm_sel_cmd, tm_sel_rnk, tm_sel_bg, tm_sel_bnk
   );

   modport slave (
      input  req_valid, req_cmd, req_rnk, req_bg, req_bnk,
      output req_ready,
      output issue_valid, issue_cmd, issue_rnk, issue_bg, issue_bnk,
      output tm_sel_cmd, tm_sel_rnk, tm_sel_bg, tm_sel_bnk
   );
endinterface

// File: rtl/cmd_timing_gate.sv
// Holds one candidate DRAM command until the registered timing counters allow it, then issues it.
// Optional CMD_GATE_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module cmd_timing_gate #(
   parameter int NUM_RNK               = 1,
   parameter int NUM_BG                = 4,
   parameter int NUM_BNK               = 4,
   parameter int RNK_SEL_WIDTH         = 1,
   parameter int BG_SEL_WIDTH          = 2,
   parameter int BNK_SEL_WIDTH         = 2,
   parameter int CMD_TYPE_WIDTH        = 3,
   parameter int TIME_CONSTRAINT_WIDTH = 8,
   parameter logic [CMD_TYPE_WIDTH-1:0] NOP_BITS  = 0,
   parameter logic [CMD_TYPE_WIDTH-1:0] PRE_BITS  = 1,
   parameter logic [CMD_TYPE_WIDTH-1:0] ACT_BITS  = 2,
   parameter logic [CMD_TYPE_WIDTH-1:0] RD_BITS   = 3,
   parameter logic [CMD_TYPE_WIDTH-1:0] WR_BITS   = 4,
   parameter logic [CMD_TYPE_WIDTH-1:0] RDA_BITS  = 5,
   parameter logic [CMD_TYPE_WIDTH-1:0] WRA_BITS  = 6,
   parameter logic [CMD_TYPE_WIDTH-1:0] PREA_BITS = 7,
   localparam int E  = NUM_RNK * NUM_BG * NUM_BNK,
   localparam int TW = TIME_CONSTRAINT_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst_n,
   cmd_timing_gate_if.slave                bus,
   output logic [E-1:0][3:0][TW-1:0]       tm_cmd_counter_i,
   output logic [NUM_RNK-1:0][3:0][TW-1:0] tm_faw_counter_i,
   output logic [NUM_RNK-1:0][3:0]         tm_faw_valid_i,
   input  logic [E-1:0][3:0][TW-1:0]       tm_cmd_counter_o,
   input  logic [NUM_RNK-1:0][3:0][TW-1:0] tm_faw_counter_o,
   input  logic [NUM_RNK-1:0][3:0]         tm_faw_valid_o
`ifdef CMD_GATE_STALL_CNT_EN
   ,
   output logic [15:0]                     stall_cnt
`endif
);

   localparam int IDXW    = RNK_SEL_WIDTH + BG_SEL_WIDTH + BNK_SEL_WIDTH;
   localparam int RNK_SHF = BG_SEL_WIDTH + BNK_SEL_WIDTH;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PEND = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CMD_TYPE_WIDTH-1:0] r_cmd;
   logic [RNK_SEL_WIDTH-1:0]  r_rnk;
   logic [BG_SEL_WIDTH-1:0]   r_bg;
   logic [BNK_SEL_WIDTH-1:0]  r_bnk;

   logic                      r_issue_valid;
   logic [CMD_TYPE_WIDTH-1:0] r_issue_cmd;
   logic [RNK_SEL_WIDTH-1:0]  r_issue_rnk;
   logic [BG_SEL_WIDTH-1:0]   r_issue_bg;
   logic [BNK_SEL_WIDTH-1:0]  r_issue_bnk;

   logic [IDXW-1:0]           w_bank_idx;
   logic [3:0][TW-1:0]        w_slots;
   logic [3:0]                w_faw_valid;
   logic                      w_prea_ok;
   logic                      w_rule_ok;
   logic                      w_legal;
   logic                      w_ready;
   logic                      w_accept;
   logic                      w_load;
   logic                      w_clear;

   assign w_bank_idx = {r_rnk, r_bg, r_bnk};

   // Counter lookups are scanned rather than indexed so out-of-range selects read as zero.
   always_comb begin
      w_slots     = '0;
      w_faw_valid = '0;
      w_prea_ok   = 1'b1;
      for (int e = 0; e < E; e++) begin
         if (e == int'(w_bank_idx)) begin
            w_slots = tm_cmd_counter_i[e];
         end
         if (((e >> RNK_SHF) == int'(r_rnk)) && (tm_cmd_counter_i[e][0] != '0)) begin
            w_prea_ok = 1'b0;
         end
      end
      for (int r = 0; r < NUM_RNK; r++) begin
         if (r == int'(r_rnk)) begin
            w_faw_valid = tm_faw_valid_i[r];
         end
      end
   end

   always_comb begin
      w_rule_ok = 1'b0;
      case (r_cmd)
         PRE_BITS:           w_rule_ok = (w_slots[0] == '0);
         ACT_BITS:           w_rule_ok = (w_slots[1] == '0) && (w_faw_valid != 4'b1111);
         RD_BITS, RDA_BITS:  w_rule_ok = (w_slots[2] == '0);
         WR_BITS, WRA_BITS:  w_rule_ok = (w_slots[3] == '0);
         PREA_BITS:          w_rule_ok = w_prea_ok;
         default:            w_rule_ok = 1'b0;
      endcase
   end

   assign w_legal       = (r_state == S_PEND) && w_rule_ok;
   assign w_ready       = (r_state == S_IDLE) || w_legal;
   assign w_accept      = bus.req_valid && w_ready && (bus.req_cmd != NOP_BITS);
   assign bus.req_ready = w_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_PEND;
               w_load      = 1'b1;
            end
         end
         S_PEND: begin
            // A legal held command frees the slot; a same-cycle accept refills it.
            if (w_legal) begin
               if (w_accept) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_clear     = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cmd   <= NOP_BITS;
         r_rnk   <= '0;
         r_bg    <= '0;
         r_bnk   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_cmd <= bus.req_cmd;
            r_rnk <= bus.req_rnk;
            r_bg  <= bus.req_bg;
            r_bnk <= bus.req_bnk;
         end else if (w_clear) begin
            r_cmd <= NOP_BITS;
            r_rnk <= '0;
            r_bg  <= '0;
            r_bnk <= '0;
         end
      end
   end

   assign bus.tm_sel_cmd = w_legal ? r_cmd : NOP_BITS;
   assign bus.tm_sel_rnk = w_legal ? r_rnk : '0;
   assign bus.tm_sel_bg  = w_legal ? r_bg  : '0;
   assign bus.tm_sel_bnk = w_legal ? r_bnk : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issue_valid <= 1'b0;
         r_issue_cmd   <= NOP_BITS;
         r_issue_rnk   <= '0;
         r_issue_bg    <= '0;
         r_issue_bnk   <= '0;
      end else begin
         r_issue_valid <= w_legal;
         r_issue_cmd   <= w_legal ? r_cmd : NOP_BITS;
         r_issue_rnk   <= w_legal ? r_rnk : '0;
         r_issue_bg    <= w_legal ? r_bg  : '0;
         r_issue_bnk   <= w_legal ? r_bnk : '0;
      end
   end

   assign bus.issue_valid = r_issue_valid;
   assign bus.issue_cmd   = r_issue_cmd;
   assign bus.issue_rnk   = r_issue_rnk;
   assign bus.issue_bg    = r_issue_bg;
   assign bus.issue_bnk   = r_issue_bnk;

   // Timing state is owned by the external update logic; this block only pipelines it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tm_cmd_counter_i <= '0;
         tm_faw_counter_i <= '0;
         tm_faw_valid_i   <= '0;
      end else begin
         tm_cmd_counter_i <= tm_cmd_counter_o;
         tm_faw_counter_i <= tm_faw_counter_o;
         tm_faw_valid_i   <= tm_faw_valid_o;
      end
   end

`ifdef CMD_GATE_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (r_issue_valid) begin
         r_stall_cnt <= '0;
      end else if ((r_state == S_PEND) && !w_legal && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cmd_timing_gate.sv
// Bench for cmd_timing_gate: directed scenarios plus random traffic against a rule-level model.
// Build with CMD_GATE_STALL_CNT_EN defined to also exercise stall_cnt.
module tb_cmd_timing_gate;

   localparam int CW = 3, RW = 1, GW = 2, KW = 2, TW = 8;
   localparam int NG = 4, NK = 4, E = 16;
   localparam int SW = CW + RW + GW + KW;
   localparam logic [CW-1:0] C_NOP = 3'd0, C_PRE = 3'd1, C_ACT = 3'd2, C_RD = 3'd3;
   localparam logic [CW-1:0] C_WR = 3'd4, C_RDA = 3'd5, C_WRA = 3'd6, C_PREA = 3'd7;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cmd_timing_gate_if #(.CMD_TYPE_WIDTH(CW), .RNK_SEL_WIDTH(RW), .BG_SEL_WIDTH(GW),
                        .BNK_SEL_WIDTH(KW)) bus ();

   logic [E-1:0][3:0][TW-1:0] ccnt_i, ccnt_o;
   logic [0:0][3:0][TW-1:0]   fcnt_i, fcnt_o;
   logic [0:0][3:0]           fval_i, fval_o;
`ifdef CMD_GATE_STALL_CNT_EN
   logic [15:0]               stall_cnt;
`endif

   cmd_timing_gate dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .bus              (bus),
      .tm_cmd_counter_i (ccnt_i),
      .tm_faw_counter_i (fcnt_i),
      .tm_faw_valid_i   (fval_i),
      .tm_cmd_counter_o (ccnt_o),
      .tm_faw_counter_o (fcnt_o),
      .tm_faw_valid_o   (fval_o)
`ifdef CMD_GATE_STALL_CNT_EN
      ,
      .stall_cnt        (stall_cnt)
`endif
   );

   // Timing-update stub: one-shot loads, otherwise every counter counts down to zero.
   logic [E-1:0][3:0]         ld_mask;
   logic [E-1:0][3:0][TW-1:0] ld_val;
   logic [3:0]                faw_drv;
   logic [3:0][TW-1:0]        fcnt_drv;

   always_comb begin
      ccnt_o = '0;
      for (int e = 0; e < E; e++)
         for (int s = 0; s < 4; s++)
            ccnt_o[e][s] = ld_mask[e][s] ? ld_val[e][s] :
                           ((ccnt_i[e][s] != '0) ? ccnt_i[e][s] - 8'd1 : '0);
      fval_o[0] = faw_drv;
      fcnt_o[0] = fcnt_drv;
   end

   // Reference model: counter values, tFAW window state, the held command, expected issues.
   int            m_cnt [E][4];
   logic [3:0]    m_fval;
   logic [3:0][TW-1:0] m_fcnt;
   bit            m_pend;
   logic [CW-1:0] m_cmd;
   logic [RW-1:0] m_rnk;
   logic [GW-1:0] m_bg;
   logic [KW-1:0] m_bnk;
   logic [SW-1:0] exp_q[$];
   bit            last_hs;
   int            errors = 0;
   int            checks = 0;

   function automatic bit model_legal();
      int b;
      b = int'(m_rnk) * NG * NK + int'(m_bg) * NK + int'(m_bnk);
      case (m_cmd)
         C_PRE:        return m_cnt[b][0] == 0;
         C_ACT:        return (m_cnt[b][1] == 0) && (m_fval != 4'b1111);
         C_RD, C_RDA:  return m_cnt[b][2] == 0;
         C_WR, C_WRA:  return m_cnt[b][3] == 0;
         C_PREA: begin
            for (int g = 0; g < NG; g++)
               for (int k = 0; k < NK; k++)
                  if (m_cnt[int'(m_rnk) * NG * NK + g * NK + k][0] != 0) return 1'b0;
            return 1'b1;
         end
         default:      return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_pend = 1'b0;
      exp_q.delete();
      for (int e = 0; e < E; e++)
         for (int s = 0; s < 4; s++) m_cnt[e][s] = 0;
      m_fval  = '0;
      m_fcnt  = '0;
      ld_mask = '0;
      last_hs = 1'b0;
   endtask

   task automatic drive_req(input bit v, input logic [CW-1:0] c, input logic [GW-1:0] g,
                            input logic [KW-1:0] k);
      bus.req_valid = v;
      bus.req_cmd   = c;
      bus.req_rnk   = '0;
      bus.req_bg    = g;
      bus.req_bnk   = k;
   endtask

   // One clock cycle: check combinational outputs mid-cycle, advance the model, check registers.
   task automatic step();
      bit lg, rdy, hs, exp_iss;
      logic [SW-1:0] exp_sel, got, exp_i;
      logic [E-1:0][3:0][TW-1:0] exp_c;
      @(negedge clk);
      lg      = m_pend && model_legal();
      rdy     = !m_pend || lg;
      exp_sel = lg ? {m_cmd, m_rnk, m_bg, m_bnk} : {C_NOP, {(SW-CW){1'b0}}};
      checks++;
      if (bus.req_ready !== rdy) begin
         errors++;
         $display("FAIL req_ready t=%0t got=%b exp=%b", $time, bus.req_ready, rdy);
      end
      got = {bus.tm_sel_cmd, bus.tm_sel_rnk, bus.tm_sel_bg, bus.tm_sel_bnk};
      checks++;
      if (got !== exp_sel) begin
         errors++;
         $display("FAIL tm_sel t=%0t got=%h exp=%h", $time, got, exp_sel);
      end
      hs = bus.req_valid && rdy;
      if (lg) exp_q.push_back(exp_sel);
      if (hs && (bus.req_cmd != C_NOP)) begin
         m_pend = 1'b1;
         m_cmd  = bus.req_cmd;
         m_rnk  = bus.req_rnk;
         m_bg   = bus.req_bg;
         m_bnk  = bus.req_bnk;
      end else if (lg) begin
         m_pend = 1'b0;
      end
      last_hs = hs;
      for (int e = 0; e < E; e++)
         for (int s = 0; s < 4; s++)
            m_cnt[e][s] = ld_mask[e][s] ? int'(ld_val[e][s]) :
                          ((m_cnt[e][s] > 0) ? m_cnt[e][s] - 1 : 0);
      m_fval = faw_drv;
      m_fcnt = fcnt_drv;
      @(posedge clk);
      #1;
      ld_mask = '0;
      exp_iss = (exp_q.size() > 0);
      exp_i   = exp_iss ? exp_q.pop_front() : {C_NOP, {(SW-CW){1'b0}}};
      checks++;
      if (bus.issue_valid !== exp_iss) begin
         errors++;
         $display("FAIL issue_valid t=%0t got=%b exp=%b", $time, bus.issue_valid, exp_iss);
      end
      got = {bus.issue_cmd, bus.issue_rnk, bus.issue_bg, bus.issue_bnk};
      checks++;
      if (got !== exp_i) begin
         errors++;
         $display("FAIL issue_fields t=%0t got=%h exp=%h", $time, got, exp_i);
      end
      for (int e = 0; e < E; e++)
         for (int s = 0; s < 4; s++) exp_c[e][s] = TW'(m_cnt[e][s]);
      checks++;
      if (ccnt_i !== exp_c) begin
         errors++;
         $display("FAIL cmd_counter t=%0t got=%h exp=%h", $time, ccnt_i, exp_c);
      end
      checks++;
      if ({fval_i[0], fcnt_i[0]} !== {m_fval, m_fcnt}) begin
         errors++;
         $display("FAIL faw_regs t=%0t got=%h exp=%h", $time, {fval_i[0], fcnt_i[0]},
                  {m_fval, m_fcnt});
      end
   endtask

   task automatic test_reset();
      drive_req(1'b0, C_NOP, '0, '0);
      faw_drv  = 4'b1010;
      fcnt_drv = 32'h1234_5678;
      ld_val   = '0;
      rst_n    = 1'b1;
      #2 rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({bus.req_ready, bus.issue_valid, bus.issue_cmd, bus.issue_rnk, bus.issue_bg,
              bus.issue_bnk, bus.tm_sel_cmd} !== {1'b1, 1'b0, C_NOP, 5'd0, C_NOP}) begin
            errors++;
            $display("FAIL reset_outputs ready=%b iv=%b ic=%h sel=%h exp ready=1 iv=0 ic=0 sel=0",
                     bus.req_ready, bus.issue_valid, bus.issue_cmd, bus.tm_sel_cmd);
         end
         checks++;
         if ({ccnt_i, fcnt_i, fval_i} !== '0) begin
            errors++;
            $display("FAIL reset_counters got=%h exp=0", {ccnt_i, fcnt_i, fval_i});
         end
         @(posedge clk);
      end
      #1 rst_n = 1'b1;
      faw_drv  = 4'b0000;
   endtask

   task automatic test_single_rd();
      drive_req(1'b1, C_RD, 2'd0, 2'd0);
      step();
      drive_req(1'b0, C_NOP, '0, '0);
      checks++;
      if (bus.tm_sel_cmd !== C_RD) begin
         errors++;
         $display("FAIL rd_tm_sel got=%h exp=%h", bus.tm_sel_cmd, C_RD);
      end
      step();
      checks++;
      if ({bus.issue_valid, bus.issue_cmd, bus.issue_bg, bus.issue_bnk} !== {1'b1, C_RD, 4'd0}) begin
         errors++;
         $display("FAIL rd_issue got v=%b c=%h bg=%h bnk=%h exp v=1 c=3 bank0",
                  bus.issue_valid, bus.issue_cmd, bus.issue_bg, bus.issue_bnk);
      end
      step();
   endtask

   task automatic test_stall();
      int k;
      ld_mask[3][2] = 1'b1;
      ld_val[3][2]  = 8'd5;
      drive_req(1'b1, C_RD, 2'd0, 2'd3);
      step();
      drive_req(1'b0, C_NOP, '0, '0);
      k = 1;
      while (!bus.issue_valid && k < 30) begin
         if (k <= 5) begin
            checks++;
            if (bus.req_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_ready edge=%0d got=%b exp=0", k, bus.req_ready);
            end
         end
         step();
         k++;
      end
      checks++;
      if (k != 7) begin
         errors++;
         $display("FAIL stall_latency got=%0d exp=7 edges", k);
      end
`ifdef CMD_GATE_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 16'd5) begin
         errors++;
         $display("FAIL stall_cnt_peak got=%0d exp=5", stall_cnt);
      end
`endif
      step();
`ifdef CMD_GATE_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL stall_cnt_clear got=%0d exp=0", stall_cnt);
      end
`endif
   endtask

   task automatic test_faw();
      faw_drv = 4'b1111;
      step();
      drive_req(1'b1, C_ACT, 2'd1, 2'd2);
      step();
      drive_req(1'b0, C_NOP, '0, '0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({bus.req_ready, bus.issue_valid} !== 2'b00) begin
            errors++;
            $display("FAIL faw_hold i=%0d got ready=%b iv=%b exp 0 0", i, bus.req_ready,
                     bus.issue_valid);
         end
         step();
      end
      faw_drv = 4'b0111;
      step();
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL faw_release_ready got=%b exp=1", bus.req_ready);
      end
      step();
      checks++;
      if ({bus.issue_valid, bus.issue_cmd, bus.issue_bg, bus.issue_bnk} !== {1'b1, C_ACT, 2'd1, 2'd2}) begin
         errors++;
         $display("FAIL faw_issue got v=%b c=%h bg=%h bnk=%h exp v=1 c=2 bg=1 bnk=2",
                  bus.issue_valid, bus.issue_cmd, bus.issue_bg, bus.issue_bnk);
      end
      faw_drv = 4'b0000;
      step();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         if (i < 3) drive_req(1'b1, C_PRE, 2'd0, 2'(i));
         else       drive_req(1'b0, C_NOP, '0, '0);
         step();
         if (i >= 1 && i <= 3) begin
            checks++;
            if ({bus.issue_valid, bus.issue_cmd, bus.issue_bnk} !== {1'b1, C_PRE, 2'(i - 1)}) begin
               errors++;
               $display("FAIL b2b_issue i=%0d got v=%b c=%h bnk=%h exp v=1 c=1 bnk=%0d", i,
                        bus.issue_valid, bus.issue_cmd, bus.issue_bnk, i - 1);
            end
         end
      end
      checks++;
      if (bus.issue_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_tail got=%b exp=0", bus.issue_valid);
      end
   endtask

   task automatic test_prea_reset();
      ld_mask[5][0] = 1'b1;
      ld_val[5][0]  = 8'd2;
      drive_req(1'b1, C_PREA, 2'd0, 2'd0);
      step();
      drive_req(1'b0, C_NOP, '0, '0);
      checks++;
      if (bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL prea_hold got=%b exp=0", bus.req_ready);
      end
      step();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({bus.req_ready, bus.issue_valid, bus.issue_cmd, bus.tm_sel_cmd, ccnt_i} !==
          {1'b1, 1'b0, C_NOP, C_NOP, {(E*4*TW){1'b0}}}) begin
         errors++;
         $display("FAIL prea_reset got ready=%b iv=%b ic=%h sel=%h exp ready=1 iv=0 ic=0 sel=0",
                  bus.req_ready, bus.issue_valid, bus.issue_cmd, bus.tm_sel_cmd);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic test_random();
      int e, s;
      for (int n = 0; n < 400; n++) begin
         if (!(bus.req_valid && !last_hs)) begin
            drive_req($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         end
         if ($urandom_range(0, 3) == 0) begin
            e = $urandom_range(0, E - 1);
            s = $urandom_range(0, 3);
            ld_mask[e][s] = 1'b1;
            ld_val[e][s]  = 8'($urandom_range(0, 4));
         end
         if ($urandom_range(0, 4) == 0)
            faw_drv = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom_range(0, 14));
         fcnt_drv = 32'($urandom);
         step();
      end
      drive_req(1'b0, C_NOP, '0, '0);
      faw_drv = 4'b0000;
      for (int i = 0; i < 8; i++) step();
   endtask

   initial begin
      test_reset();
      test_single_rd();
      test_stall();
      test_faw();
      test_back_to_back();
      test_prea_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
